// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the core and a synchronous instruction ROM.
// Owns the fetch PC, absorbs the ROM's one-cycle read latency and buffers each word with
// its byte PC in a DEPTH-entry FIFO that feeds decode over a valid/ready handshake.
// A taken branch flushes the FIFO and any in-flight read.
// Parameters: ROM_AW (ROM word-address width), DEPTH (FIFO entries, >= 2),
//             RESET_PC (word-aligned first fetch address).
// Ports: clk, reset (sync, active-high), enable (allow new reads),
//        branch_taken/branch_target (redirect), rom_addr/rom_q (ROM side),
//        ins/PC/ins_valid/ins_ready (decode side).
// Optional macro FETCH_BYPASS_EN: with an empty FIFO the arriving ROM word is
// presented to decode in the same cycle it returns.
module fetch_unit #(
  parameter int          ROM_AW   = 8,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_q,
  output logic [31:0]       ins,
  output logic [31:0]       PC,
  output logic              ins_valid,
  input  logic              ins_ready
);
  localparam int          PW = $clog2(DEPTH);
  localparam int          CW = $clog2(DEPTH + 1);
  localparam logic [31:0] DU = 32'(DEPTH);
  logic [31:0]   fetch_pc, inflight_pc;
  logic          inflight;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] head, tail, head_nx, tail_nx;
  logic [CW-1:0] count;
  logic          nempty, byp, pop, fifo_pop, wr, issue;
  assign rom_addr = fetch_pc[ROM_AW+1:2];
  assign nempty   = count != '0;
`ifdef FETCH_BYPASS_EN
  // a word returning during a branch is discarded, so it must not be shown either
  assign byp = ~nempty & inflight & ~branch_taken;
`else
  assign byp = 1'b0;
`endif
  assign ins_valid = nempty | byp;
  assign ins       = nempty ? mem[head][63:32] : byp ? rom_q : '0;
  assign PC        = nempty ? mem[head][31:0] : byp ? inflight_pc : '0;
  assign pop       = ins_valid & ins_ready;
  assign fifo_pop  = pop & nempty & ~branch_taken;
  // credit check: buffered + in-flight words after this cycle's pop must leave a free slot
  assign issue     = enable & ~branch_taken & (32'(count) + 32'(inflight) < DU + 32'(pop));
  assign wr        = inflight & ~branch_taken & ~(byp & ins_ready);
  assign head_nx   = (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
  assign tail_nx   = (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (branch_taken) begin
      fetch_pc <= branch_target & ~32'd3;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (wr) tail <= tail_nx;
      if (fifo_pop) head <= head_nx;
      count <= count + CW'(wr) - CW'(fifo_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (wr & ~reset) mem[tail] <= {rom_q, inflight_pc};
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits between the processor core and the synchronous instruction ROM. It owns the fetch program counter, drives the ROM word address, and absorbs the ROM's one-cycle read latency. Fetched words are buffered with their byte PC in a small FIFO and handed to decode over a valid/ready handshake. A taken branch flushes everything in flight.

## Interface
- `ROM_AW`, default 8: ROM word-address width.
- `DEPTH`, default 2: output FIFO entries; must be ≥ 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address; must be word-aligned.

Ports:
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `enable` input 1: allows new ROM reads to be issued.
- `branch_taken` input 1: redirect request, sampled every cycle.
- `branch_target` input 32: redirect byte address; bits [1:0] are ignored.
- `rom_addr` output ROM_AW: equals `fetch_pc[ROM_AW+1:2]` (combinational).
- `rom_q` input 32: ROM data, valid in the cycle after the address was sampled.
- `ins` output 32: instruction at the FIFO head.
- `PC` output 32: byte address of `ins`.
- `ins_valid` output 1: the FIFO head is valid.
- `ins_ready` input 1: decode accepts the head.

## Operation
- State:
  - `fetch_pc` (32 bits).
  - `inflight` (1 bit) and `inflight_pc` (32 bits).
  - FIFO of DEPTH entries, each {ins, pc}, with head/tail pointers and `count`.
- `pop` = `ins_valid & ins_ready`.
- `issue` = `enable & ~branch_taken & (count + inflight − pop < DEPTH)`.
- On `issue`:
  - `inflight` is set to 1 and `inflight_pc` to `fetch_pc`.
  - `fetch_pc` advances by 4, modulo 2^32.
- With no `issue`, `inflight` clears and `fetch_pc` holds.
- When `inflight` = 1, `{rom_q, inflight_pc}` is written at the FIFO tail in that cycle.
- Branch (`branch_taken` = 1):
  - Overrides all other activity.
  - FIFO is cleared (count = 0) and `inflight` cleared; the ROM word arriving in that cycle is discarded.
  - `fetch_pc` is set to `{branch_target[31:2], 2'b00}`.
  - No pop is performed in that cycle.
- `enable` low stops issues only. In-flight data still lands in the FIFO, and the output side keeps draining.
- `ins`/`PC` hold their values while `ins_valid` = 1 and `ins_ready` = 0.
- `rom_addr` wraps at 2^ROM_AW words; `fetch_pc` itself does not wrap below 2^32.
- FIFO overflow is structurally impossible because issue is gated by the credit check above. A bench assertion must confirm the tail is never written while `count` = DEPTH without a simultaneous pop.

## Timing
- Reset values:
  - `fetch_pc` = RESET_PC, `inflight` = 0, `count` = 0.
  - `ins_valid` = 0, `ins` = 0, `PC` = 0.
  - `rom_addr` = RESET_PC[ROM_AW+1:2].
- Reset asserted mid-operation discards all buffered and in-flight words on the next edge.
- Fetch latency, with cycle 0 as the first cycle `reset` is low and `enable` is 1:
  - Issue in cycle 0.
  - `rom_q` valid in cycle 1 and written to the FIFO.
  - `ins_valid` = 1 in cycle 2 with `PC` = RESET_PC.
- Redirect latency: with `branch_taken` in cycle n, the target issues in cycle n+1 and `ins_valid` is set in cycle n+3.
- Throughput: 1 instruction/cycle sustained while `enable` and `ins_ready` are both held at 1.
- Backpressure: with `ins_ready` = 0, at most DEPTH words are accepted before issues stop; issuing resumes in the cycle of the next pop.

## Configuration
- `FETCH_BYPASS_EN`:
  - When defined, and `count` = 0 with `inflight` = 1, `rom_q`/`inflight_pc` drive `ins`/`PC` combinationally and `ins_valid` = 1 in that same cycle.
  - If `ins_ready` = 1 in that cycle, the word is consumed and not written to the FIFO.
  - Fetch latency becomes 1 cycle and redirect latency becomes 2 cycles.
- When undefined, all output comes from the FIFO, using the latencies given under Timing.

## Test plan
- Reset release with RESET_PC = 0, ROM[k] = 32'hE000_0000 + k, `ins_ready` = 1:
  - `ins_valid` rises in cycle 2.
  - Consecutive outputs are PC 0, 4, 8, 12 with ins E0000000, E0000001, E0000002, E0000003, one per cycle.
- Backpressure: hold `ins_ready` = 0 for 6 cycles after the first valid:
  - `count` saturates at 2.
  - `ins`/`PC` are stable at E0000000/0.
  - On release, the sequence continues with no gaps and no duplicates.
- Branch while the FIFO holds 2 words and one read is in flight, `branch_target` = 32'h0000_0043:
  - The next valid output is PC 0x40, ins E0000010, arriving 3 cycles after the branch.
  - No stale word appears.
- `enable` dropped for 4 cycles mid-stream with `ins_ready` = 1: at most 1 further word appears, then output resumes in PC order.
- Wrap with ROM_AW = 8 and a branch to 32'h0000_03FC:
  - Outputs are PC 0x3FC (ROM[255]), then PC 0x400 with `rom_addr` = 0 (ROM[0]).
- Reset asserted for 1 cycle while 2 words are buffered: `ins_valid` = 0 in the next cycle, then the RESET_PC sequence restarts.
